cr_cp0_lpmd_seq: RTL and testbench
==================================

Name: cr_cp0_lpmd_seq

Overview:
- Low-power entry/exit sequencer between the core low-power request (lpmd_b from CP0) and the SoC clock/power controller.
- Drains the bus, then gates the core clock.
- For STOP mode it additionally sequences isolation, retention save, and a power-off/power-on handshake. Wake-up runs the same steps in reverse.
- Produces the system-view lpmd_b that CP0 treats as "CPU in low power".

Parameters:
- ISO_DLY, 4, cycles isolation is held before retention save (and before isolation release on exit); legal range 1..15.
- RET_DLY, 4, cycles retention-save / restore strobe is held; legal range 1..15.
- CNT_W, 4, width of the shared delay counter.

Ports:
- lpmd_sm_clk  in  1  sequencer clock; free-running while seq_sm_clk_en=1.
- cpurst_b  in  1  reset, asynchronous, active-low.
- cp0_seq_lpmd_b  in  2  core request: 11 run, 10 wait, 01 doze, 00 stop.
- seq_wk_req  in  1  wake request (interrupt/debug), level.
- biu_seq_idle  in  1  bus has no outstanding transactions.
- pmu_seq_pwr_ack  in  1  power controller ack; level follows the power state (1 = off).
- seq_sys_view_lpmd_b  out  2  system-view mode; feeds sysio_cp0_sys_view_lpmd_b.
- seq_clk_gate_req  out  1  request core clock gating.
- seq_iso_en  out  1  isolation enable.
- seq_ret_save  out  1  retention save strobe (level, RET_DLY cycles).
- seq_ret_restore  out  1  retention restore strobe (level, RET_DLY cycles).
- seq_pwr_off_req  out  1  power-off request to PMU.
- seq_busy  out  1  state != IDLE.
- seq_sm_clk_en  out  1  seq_busy | (cp0_seq_lpmd_b != 11).

Behaviour:
Reset values:
- State IDLE; all outputs 0 except seq_sys_view_lpmd_b = 11.
- Counter 0; captured mode register mode_q = 11.

States (4-bit encoding) and transitions:
- IDLE: cp0_seq_lpmd_b != 11 and !seq_wk_req -> DRAIN, capturing mode_q = cp0_seq_lpmd_b. Wake has priority over a new request in the same cycle.
- DRAIN: seq_wk_req -> IDLE (abort; no side effects). Otherwise biu_seq_idle -> GATE.
- GATE: seq_clk_gate_req = 1.
  - mode_q = 00 -> ISO.
  - Otherwise seq_wk_req -> UNGATE.
- ISO: seq_iso_en = 1 for ISO_DLY cycles, then -> SAVE. seq_wk_req -> DEISO.
- SAVE: seq_ret_save = 1 for RET_DLY cycles, then -> PWROFF. seq_wk_req -> DEISO, and the save strobe drops immediately.
- PWROFF: seq_pwr_off_req = 1. Wait for pmu_seq_pwr_ack = 1 -> OFF. No abort in this state; a wake is held off until the ack arrives.
- OFF: req held at 1. seq_wk_req -> PWRON.
- PWRON: req = 0. Wait for pmu_seq_pwr_ack = 0 -> RESTORE.
- RESTORE: seq_ret_restore = 1 for RET_DLY cycles -> DEISO.
- DEISO: iso still 1 for ISO_DLY cycles -> UNGATE.
- UNGATE: gate_req = 0 and iso = 0 this cycle -> IDLE. mode_q returns to 11 on exit.

Held outputs:
- seq_clk_gate_req = 1 in GATE through DEISO.
- seq_iso_en = 1 in ISO, SAVE, PWROFF, OFF, PWRON, RESTORE, DEISO.
- seq_sys_view_lpmd_b = mode_q from DRAIN entry until return to IDLE. The core therefore sees "in low power" for the whole sequence.

Counter:
- Loads DLY-1 on entry to a timed state, decrements each cycle, and transitions on 0.
- A timed state therefore lasts exactly DLY cycles. Decrement saturates at 0.
- Outputs are registered from state (Moore), so they change one cycle after the transition condition.
- A change of cp0_seq_lpmd_b mid-sequence is ignored; mode_q is frozen.
- Asynchronous reset in any state returns everything to reset values at once, including dropping seq_pwr_off_req. The PMU treats that as a power-on request.

Decomposition:
- Package cr_cp0_lpmd_pkg: state encodings; LPMD_RUN/WAIT/DOZE/STOP constants (11/10/01/00).
- Sub-module cr_cp0_lpmd_dly_cnt: loadable CNT_W down-counter with a zero flag, used for all timed states.
- The FSM and output decode stay in the top level.

Test Plan:
1. WAIT entry/exit: lpmd_b = 10, biu_seq_idle = 1.
   - Expect DRAIN, then GATE with gate_req = 1 and sys_view = 10.
   - After seq_wk_req: UNGATE, then IDLE with sys_view = 11; iso is never asserted.
2. DRAIN abort: lpmd_b = 00, biu_seq_idle = 0, seq_wk_req pulsed two cycles later.
   - Expect return to IDLE with no gate/iso/save asserted.
3. Full STOP cycle with ISO_DLY = 4, RET_DLY = 4, PMU acking after 3 cycles.
   - iso asserts for 4 cycles before save, save asserts for 4 cycles, then pwr_off_req = 1.
   - Wake: req = 0, then restore for 4 cycles, iso releases 4 cycles later.
4. Wake during SAVE (cycle 2): save drops next cycle, DEISO holds iso for 4 cycles, then IDLE. pwr_off_req is never asserted.
5. Wake during PWROFF before ack: req stays 1 until ack = 1, passes through OFF for 1 cycle, then PWRON.
6. cpurst_b asserted while in OFF: immediately pwr_off_req = 0, iso = 0, gate = 0, sys_view = 11, busy = 0.

Source files
------------

// File: rtl/cr_cp0_lpmd_pkg.sv
// Shared encodings for the CP0 low-power entry/exit sequencer.
package cr_cp0_lpmd_pkg;

    localparam logic [1:0] LPMD_RUN  = 2'b11;
    localparam logic [1:0] LPMD_WAIT = 2'b10;
    localparam logic [1:0] LPMD_DOZE = 2'b01;
    localparam logic [1:0] LPMD_STOP = 2'b00;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_DRAIN   = 4'd1,
        S_GATE    = 4'd2,
        S_ISO     = 4'd3,
        S_SAVE    = 4'd4,
        S_PWROFF  = 4'd5,
        S_OFF     = 4'd6,
        S_PWRON   = 4'd7,
        S_RESTORE = 4'd8,
        S_DEISO   = 4'd9,
        S_UNGATE  = 4'd10
    } seq_state_e;

    function automatic logic is_timed(seq_state_e s);
        return (s == S_ISO) || (s == S_SAVE) ||
               (s == S_RESTORE) || (s == S_DEISO);
    endfunction

endpackage

// File: rtl/cr_cp0_lpmd_dly_cnt.sv
// Loadable saturating down-counter shared by all timed sequencer states.
module cr_cp0_lpmd_dly_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             lpmd_sm_clk,
    input  logic             cpurst_b,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge lpmd_sm_clk or negedge cpurst_b) begin
        if (!cpurst_b)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cr_cp0_lpmd_seq.sv
// Low-power sequencer: bus drain, clock gate and, for STOP, the
// isolation / retention / power-off handshake, unwound on wake.
module cr_cp0_lpmd_seq
    import cr_cp0_lpmd_pkg::*;
#(
    parameter int ISO_DLY = 4,
    parameter int RET_DLY = 4,
    parameter int CNT_W   = 4
) (
    input  logic       lpmd_sm_clk,
    input  logic       cpurst_b,
    input  logic [1:0] cp0_seq_lpmd_b,
    input  logic       seq_wk_req,
    input  logic       biu_seq_idle,
    input  logic       pmu_seq_pwr_ack,
    output logic [1:0] seq_sys_view_lpmd_b,
    output logic       seq_clk_gate_req,
    output logic       seq_iso_en,
    output logic       seq_ret_save,
    output logic       seq_ret_restore,
    output logic       seq_pwr_off_req,
    output logic       seq_busy,
    output logic       seq_sm_clk_en
);

    localparam logic [CNT_W-1:0] ISO_LD = CNT_W'(ISO_DLY - 1);
    localparam logic [CNT_W-1:0] RET_LD = CNT_W'(RET_DLY - 1);

    seq_state_e       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    logic [1:0] view_q;
    logic       gate_q, iso_q, save_q, rest_q, off_q, busy_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE:
                if (cp0_seq_lpmd_b != LPMD_RUN && !seq_wk_req) begin
                    state_d = S_DRAIN;
                    mode_d  = cp0_seq_lpmd_b;
                end
            S_DRAIN:
                if (seq_wk_req)        state_d = S_IDLE;
                else if (biu_seq_idle) state_d = S_GATE;
            S_GATE:
                if (mode_q == LPMD_STOP) state_d = S_ISO;
                else if (seq_wk_req)     state_d = S_UNGATE;
            S_ISO:
                if (seq_wk_req)    state_d = S_DEISO;
                else if (cnt_zero) state_d = S_SAVE;
            S_SAVE:
                if (seq_wk_req)    state_d = S_DEISO;
                else if (cnt_zero) state_d = S_PWROFF;
            S_PWROFF:
                if (pmu_seq_pwr_ack) state_d = S_OFF;
            S_OFF:
                if (seq_wk_req) state_d = S_PWRON;
            S_PWRON:
                if (!pmu_seq_pwr_ack) state_d = S_RESTORE;
            S_RESTORE:
                if (cnt_zero) state_d = S_DEISO;
            S_DEISO:
                if (cnt_zero) state_d = S_UNGATE;
            S_UNGATE:
                state_d = S_IDLE;
            default:
                state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE)
            mode_d = LPMD_RUN;
    end

    // Counter restarts whenever a timed state is newly entered.
    assign cnt_load = (state_d != state_q) && is_timed(state_d);
    assign cnt_val  = (state_d == S_ISO || state_d == S_DEISO) ?
                      ISO_LD : RET_LD;

    cr_cp0_lpmd_dly_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
        .lpmd_sm_clk (lpmd_sm_clk),
        .cpurst_b    (cpurst_b),
        .load_i      (cnt_load),
        .load_val_i  (cnt_val),
        .zero_o      (cnt_zero)
    );

    // Outputs are flopped from the next state so they track state_q.
    always_ff @(posedge lpmd_sm_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= S_IDLE;
            mode_q  <= LPMD_RUN;
            view_q  <= LPMD_RUN;
            gate_q  <= 1'b0;
            iso_q   <= 1'b0;
            save_q  <= 1'b0;
            rest_q  <= 1'b0;
            off_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            view_q  <= mode_d;
            gate_q  <= state_d inside {S_GATE, S_ISO, S_SAVE, S_PWROFF,
                                       S_OFF, S_PWRON, S_RESTORE, S_DEISO};
            iso_q   <= state_d inside {S_ISO, S_SAVE, S_PWROFF, S_OFF,
                                       S_PWRON, S_RESTORE, S_DEISO};
            save_q  <= (state_d == S_SAVE);
            rest_q  <= (state_d == S_RESTORE);
            off_q   <= state_d inside {S_PWROFF, S_OFF};
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign seq_sys_view_lpmd_b = view_q;
    assign seq_clk_gate_req    = gate_q;
    assign seq_iso_en          = iso_q;
    assign seq_ret_save        = save_q;
    assign seq_ret_restore     = rest_q;
    assign seq_pwr_off_req     = off_q;
    assign seq_busy            = busy_q;
    assign seq_sm_clk_en       = busy_q | (cp0_seq_lpmd_b != LPMD_RUN);

endmodule

// File: tb/tb_cr_cp0_lpmd_seq.sv
// Directed table-driven bench for the low-power sequencer.
`timescale 1ns/1ps
module tb_cr_cp0_lpmd_seq;

    logic       clk;
    logic       rst_b;
    logic [1:0] lpmd;
    logic       wk, idle, ack;
    logic [1:0] sview;
    logic       gate, iso, save, rest, poff, busy, clken;

    int n_run;
    int n_fail;

    cr_cp0_lpmd_seq #(.ISO_DLY(4), .RET_DLY(4), .CNT_W(4)) dut (
        .lpmd_sm_clk         (clk),
        .cpurst_b            (rst_b),
        .cp0_seq_lpmd_b      (lpmd),
        .seq_wk_req          (wk),
        .biu_seq_idle        (idle),
        .pmu_seq_pwr_ack     (ack),
        .seq_sys_view_lpmd_b (sview),
        .seq_clk_gate_req    (gate),
        .seq_iso_en          (iso),
        .seq_ret_save        (save),
        .seq_ret_restore     (rest),
        .seq_pwr_off_req     (poff),
        .seq_busy            (busy),
        .seq_sm_clk_en       (clken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rb;
        logic [1:0] lpmd;
        bit         wk;
        bit         idle;
        bit         ack;
        int         rep;
        logic [8:0] exp;
        string      nm;
    } vec_t;

    vec_t tbl[$];

    // exp = {sys_view[1:0], gate, iso, save, restore, pwr_off, busy, clk_en}
    function automatic void add(bit rb, logic [1:0] l, bit w, bit i,
                                bit a, int r, logic [8:0] e, string n);
        vec_t v;
        v.rb = rb; v.lpmd = l; v.wk = w; v.idle = i; v.ack = a;
        v.rep = r; v.exp = e; v.nm = n;
        tbl.push_back(v);
    endfunction

    function automatic logic [8:0] outs();
        return {sview, gate, iso, save, rest, poff, busy, clken};
    endfunction

    task automatic check(string nm, logic [8:0] exp);
        logic [8:0] act;
        act = outs();
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp,
                     $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        lpmd = 2'b11; wk = 1'b0; idle = 1'b0; ack = 1'b0;
        tick();
        tick();
        rst_b = 1'b1;
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;

        add(1, 2'b10, 0, 1, 0, 1, 9'b10_0000011, "w_drain");
        add(0, 2'b10, 0, 1, 0, 2, 9'b10_1000011, "w_gate");
        add(0, 2'b10, 1, 1, 0, 1, 9'b10_0000011, "w_ungate");
        add(0, 2'b11, 0, 1, 0, 1, 9'b11_0000000, "w_idle");

        add(1, 2'b00, 0, 0, 0, 2, 9'b00_0000011, "a_drain");
        add(0, 2'b00, 1, 0, 0, 1, 9'b11_0000001, "a_abort");
        add(0, 2'b00, 1, 0, 0, 1, 9'b11_0000001, "a_wkprio");
        add(0, 2'b11, 0, 0, 0, 1, 9'b11_0000000, "a_idle");

        add(1, 2'b00, 0, 1, 0, 1, 9'b00_0000011, "s_drain");
        add(0, 2'b00, 0, 1, 0, 1, 9'b00_1000011, "s_gate");
        add(0, 2'b00, 0, 1, 0, 4, 9'b00_1100011, "s_iso");
        add(0, 2'b00, 0, 1, 0, 4, 9'b00_1110011, "s_save");
        add(0, 2'b00, 0, 1, 0, 3, 9'b00_1100111, "s_pwroff");
        add(0, 2'b00, 0, 1, 1, 2, 9'b00_1100111, "s_off");
        add(0, 2'b00, 1, 1, 1, 2, 9'b00_1100011, "s_pwron");
        add(0, 2'b00, 0, 1, 0, 4, 9'b00_1101011, "s_restore");
        add(0, 2'b11, 0, 1, 0, 4, 9'b00_1100011, "s_deiso");
        add(0, 2'b11, 0, 1, 0, 1, 9'b00_0000011, "s_ungate");
        add(0, 2'b11, 0, 1, 0, 1, 9'b11_0000000, "s_idle");

        add(1, 2'b00, 0, 1, 0, 1, 9'b00_0000011, "v_drain");
        add(0, 2'b00, 0, 1, 0, 1, 9'b00_1000011, "v_gate");
        add(0, 2'b00, 0, 1, 0, 4, 9'b00_1100011, "v_iso");
        add(0, 2'b00, 0, 1, 0, 2, 9'b00_1110011, "v_save");
        add(0, 2'b00, 1, 1, 0, 1, 9'b00_1100011, "v_deiso_wk");
        add(0, 2'b00, 0, 1, 0, 3, 9'b00_1100011, "v_deiso");
        add(0, 2'b00, 0, 1, 0, 1, 9'b00_0000011, "v_ungate");
        add(0, 2'b11, 0, 1, 0, 1, 9'b11_0000000, "v_idle");

        add(1, 2'b00, 0, 1, 0, 1, 9'b00_0000011, "p_drain");
        add(0, 2'b00, 0, 1, 0, 1, 9'b00_1000011, "p_gate");
        add(0, 2'b00, 0, 1, 0, 4, 9'b00_1100011, "p_iso");
        add(0, 2'b00, 0, 1, 0, 4, 9'b00_1110011, "p_save");
        add(0, 2'b00, 0, 1, 0, 1, 9'b00_1100111, "p_pwroff");
        add(0, 2'b00, 1, 1, 0, 2, 9'b00_1100111, "p_pwroff_wk");
        add(0, 2'b00, 1, 1, 1, 1, 9'b00_1100111, "p_off");
        add(0, 2'b00, 1, 1, 1, 1, 9'b00_1100011, "p_pwron");
        add(0, 2'b00, 0, 1, 0, 4, 9'b00_1101011, "p_restore");
        add(0, 2'b00, 0, 1, 0, 4, 9'b00_1100011, "p_deiso");
        add(0, 2'b00, 0, 1, 0, 1, 9'b00_0000011, "p_ungate");
        add(0, 2'b11, 0, 1, 0, 1, 9'b11_0000000, "p_idle");

        do_reset();
        check("reset", 9'b11_0000000);

        foreach (tbl[k]) begin
            if (tbl[k].rb)
                do_reset();
            lpmd = tbl[k].lpmd;
            wk   = tbl[k].wk;
            idle = tbl[k].idle;
            ack  = tbl[k].ack;
            for (int r = 0; r < tbl[k].rep; r++) begin
                tick();
                check(tbl[k].nm, tbl[k].exp);
            end
        end

        do_reset();
        lpmd = 2'b00; idle = 1'b1; wk = 1'b0; ack = 1'b0;
        repeat (11) tick();
        ack = 1'b1;
        repeat (2) tick();
        check("r_off", 9'b00_1100111);
        #3;
        rst_b = 1'b0;
        #1;
        check("r_async", 9'b11_0000001);
        tick();
        check("r_held", 9'b11_0000001);
        rst_b = 1'b1;
        lpmd = 2'b11; ack = 1'b0;
        tick();
        check("r_idle", 9'b11_0000000);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
